// File: rtl/i3_router_wrarb_rr.sv
// Packet-level round-robin write arbiter: three input ports share one output FIFO.
// Optional per-port tail counters on pkt_cnt when WRARB_PKTCNT_EN is defined.
module i3_router_wrarb_rr #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_req1,
  input  logic       input_req2,
  input  logic       input_req3,
  input  logic [2:0] head1,
  input  logic [2:0] head2,
  input  logic [2:0] head3,
  input  logic       FIFO_full,
  output logic       input_bussy1,
  output logic       input_bussy2,
  output logic       input_bussy3,
  output logic       FIFO_wr,
  output logic [1:0] select,
  output logic [1:0] owner,
  output logic       proto_err,
`ifdef WRARB_PKTCNT_EN
  output logic       timeout,
  output logic [47:0] pkt_cnt
`else
  output logic       timeout
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [2:0]      T_HEAD = 3'b001;
  localparam logic [2:0]      T_BODY = 3'b010;
  localparam logic [2:0]      T_TAIL = 3'b110;
  localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

  state_t          r_state;
  logic [1:0]      r_owner;
  logic [1:0]      r_rr;
  logic [TO_W-1:0] r_wd;
  logic            r_proto_err;
  logic            r_timeout;

  logic [3:0]       w_req;
  logic [3:0][2:0]  w_typ;
  logic [2:0]       w_cand;
  logic             w_any;
  logic [1:0]       w_win;
  logic             w_oreq;
  logic [2:0]       w_otyp;
  logic             w_body;
  logic             w_tail;
  logic             w_bad;
  logic             w_owr;
  logic [TO_W-1:0]  w_wd_nxt;
  logic             w_expire;
  logic             w_wr;
  logic [1:0]       w_sel;
  logic [3:0]       w_busy;

  // Slot 3 is a dummy so an idle owner code (11) never indexes out of range.
  assign w_req = {1'b0, input_req3, input_req2, input_req1};
  assign w_typ = {3'b000, head3, head2, head1};

  always_comb begin
    for (int unsigned i = 0; i < 3; i++)
      w_cand[i] = w_req[i] && (w_typ[i] == T_HEAD);
  end
  assign w_any = |w_cand;

  // First candidate strictly after the rr pointer, cyclic 1->2->3->1.
  always_comb begin
    w_win = 2'd0;
    unique case (r_rr)
      2'd0:    w_win = w_cand[1] ? 2'd1 : (w_cand[2] ? 2'd2 : 2'd0);
      2'd1:    w_win = w_cand[2] ? 2'd2 : (w_cand[0] ? 2'd0 : 2'd1);
      default: w_win = w_cand[0] ? 2'd0 : (w_cand[1] ? 2'd1 : 2'd2);
    endcase
  end

  assign w_oreq   = w_req[r_owner];
  assign w_otyp   = w_typ[r_owner];
  assign w_body   = w_oreq && ((w_otyp == T_BODY) || (w_otyp == T_TAIL));
  assign w_tail   = w_oreq && (w_otyp == T_TAIL);
  assign w_bad    = (r_state == LOCK) && w_oreq && !w_body;
  assign w_owr    = (r_state == LOCK) && w_body && !FIFO_full;
  assign w_wd_nxt = (r_wd == '1) ? r_wd : r_wd + 1'b1;
  assign w_expire = (TIMEOUT != 0) && (w_wd_nxt == TO_VAL);

  always_comb begin
    w_wr   = 1'b0;
    w_sel  = 2'b00;
    w_busy = '1;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (!FIFO_full && w_any) begin
            w_wr          = 1'b1;
            w_sel         = w_win;
            w_busy[w_win] = 1'b0;
          end
        end
        LOCK: begin
          w_sel = r_owner;
          if (w_body) begin
            w_wr            = !FIFO_full;
            w_busy[r_owner] = FIFO_full;
          end else if (w_bad) begin
            w_busy[r_owner] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Priority inside LOCK: protocol error, then owner write (tail), then watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= 2'b11;
      r_rr        <= 2'd2;
      r_wd        <= '0;
      r_proto_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_proto_err <= 1'b0;
      r_timeout   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_wd <= '0;
          if (!FIFO_full && w_any) begin
            r_state <= LOCK;
            r_owner <= w_win;
            r_rr    <= w_win;
          end
        end
        LOCK: begin
          if (w_bad) begin
            r_state     <= IDLE;
            r_owner     <= 2'b11;
            r_wd        <= '0;
            r_proto_err <= 1'b1;
          end else if (w_owr) begin
            r_wd <= '0;
            if (w_tail) begin
              r_state <= IDLE;
              r_owner <= 2'b11;
            end
          end else if (w_expire) begin
            r_state   <= IDLE;
            r_owner   <= 2'b11;
            r_wd      <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= w_wd_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign input_bussy1 = w_busy[0];
  assign input_bussy2 = w_busy[1];
  assign input_bussy3 = w_busy[2];
  assign FIFO_wr      = w_wr;
  assign select       = w_sel;
  assign owner        = rst ? 2'b11 : r_owner;
  assign proto_err    = !rst && r_proto_err;
  assign timeout      = !rst && r_timeout;

`ifdef WRARB_PKTCNT_EN
  logic [2:0][15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_owr && w_tail) begin
      unique case (r_owner)
        2'd0:    r_cnt[0] <= r_cnt[0] + 16'd1;
        2'd1:    r_cnt[1] <= r_cnt[1] + 16'd1;
        default: r_cnt[2] <= r_cnt[2] + 16'd1;
      endcase
    end
  end

  assign pkt_cnt = r_cnt;
`endif

endmodule
